// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : 5-stage pipeline sequencing: load-use stalls, branch/jump flushes,
//            data-memory wait FSM with timeout-to-halt, perf counters.
// Revision : 1.0
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int WAIT_MAX = 255,
    parameter int CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [4:0]       i_id_rs,
    input  logic [4:0]       i_id_rt,
    input  logic             i_id_uses_rs,
    input  logic             i_id_uses_rt,
    input  logic             i_id_jump,
    input  logic             i_ex_memToReg,
    input  logic [4:0]       i_ex_wreg,
    input  logic             i_ex_br_taken,
    input  logic             i_mem_rd,
    input  logic             i_mem_wr,
    input  logic             i_dmem_ready,
    output logic             o_pc_en,
    output logic             o_ifid_en,
    output logic             o_idex_en,
    output logic             o_exmem_en,
    output logic             o_ifid_flush,
    output logic             o_idex_flush,
    output logic             o_memwb_bubble,
    output logic             o_dmem_req,
    output logic             o_dmem_err,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam int WC_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic w_memop;
    logic w_halted;
    logic w_freeze;
    logic w_load_use;
    logic w_stall_inc;
    logic w_flush_inc;

    assign w_memop  = i_mem_rd | i_mem_wr;
    assign w_halted = (state_q == ST_HALT);
    assign w_freeze = w_halted | (w_memop & ~i_dmem_ready);

    assign w_load_use = i_ex_memToReg && (i_ex_wreg != 5'd0) &&
                        ((i_id_uses_rs && (i_ex_wreg == i_id_rs)) ||
                         (i_id_uses_rt && (i_ex_wreg == i_id_rt)));

    // Stage controls are Mealy: dmem_ready reaches the enables in the same cycle.
    always_comb begin
        o_pc_en        = 1'b1;
        o_ifid_en      = 1'b1;
        o_idex_en      = 1'b1;
        o_exmem_en     = 1'b1;
        o_ifid_flush   = 1'b0;
        o_idex_flush   = 1'b0;
        o_memwb_bubble = 1'b0;
        o_dmem_req     = w_memop & ~w_halted;
        w_stall_inc    = 1'b0;
        w_flush_inc    = 1'b0;
        if (i_rst) begin
            o_pc_en        = 1'b0;
            o_ifid_en      = 1'b0;
            o_idex_en      = 1'b0;
            o_exmem_en     = 1'b0;
            o_ifid_flush   = 1'b1;
            o_idex_flush   = 1'b1;
            o_memwb_bubble = 1'b1;
            o_dmem_req     = 1'b0;
        end else if (w_freeze) begin
            o_pc_en        = 1'b0;
            o_ifid_en      = 1'b0;
            o_idex_en      = 1'b0;
            o_exmem_en     = 1'b0;
            o_memwb_bubble = 1'b1;
        end else if (i_ex_br_taken) begin
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
            w_flush_inc  = 1'b1;
        end else if (w_load_use) begin
            o_pc_en      = 1'b0;
            o_ifid_en    = 1'b0;
            o_idex_flush = 1'b1;
            w_stall_inc  = 1'b1;
        end else if (i_id_jump) begin
            o_ifid_flush = 1'b1;
            w_flush_inc  = 1'b1;
        end
    end

    // Ready takes priority over the timeout check in MEM_WAIT.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        case (state_q)
            ST_RUN: begin
                if (w_memop && !i_dmem_ready) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WC_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (i_dmem_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WC_W'(WAIT_MAX)) begin
                    state_d = ST_HALT;
                    err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
            if (w_stall_inc && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (w_flush_inc && (flush_cnt_q != {CNT_W{1'b1}}))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign o_dmem_err  = err_q;
    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire
